// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - iomem-bus countdown timer with prescaler, auto-reload and level irq
// Optional CMP register and PWM output are built when IOMEM_TIMER_PWM_EN is defined.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq,
  output logic        pwm_out
);

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_RELOAD   = 8'h08;
  localparam logic [7:0] OFF_COUNT    = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_CMP      = 8'h14;

  logic                  ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]           reload, count;
  logic                  expired;
  logic [31:0]           cmp;

  logic        sel, accept, wr_en;
  logic [7:0]  off;
  logic [31:0] rd_val, wr_word;
  logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status, wr_cmp;
  logic        tick, expire;

  assign off    = iomem_addr[7:0];
  assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept = sel && !iomem_ready;
  assign wr_en  = accept && (iomem_wstrb != 4'b0000);

`ifdef IOMEM_TIMER_PWM_EN
  localparam bit HAS_CMP = 1'b1;
`else
  localparam bit HAS_CMP = 1'b0;
  assign cmp = 32'd0;
`endif

  always_comb begin
    rd_val = 32'd0;
    case (off)
      OFF_CTRL:     rd_val = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
      OFF_PRESCALE: rd_val = 32'(prescale);
      OFF_RELOAD:   rd_val = reload;
      OFF_COUNT:    rd_val = count;
      OFF_STATUS:   rd_val = {31'd0, expired};
      OFF_CMP:      rd_val = HAS_CMP ? cmp : 32'd0;
      default:      rd_val = 32'd0;
    endcase
  end

  // The read view is the current register value, so merging strobed lanes into it gives the write result.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = iomem_wstrb[b] ? iomem_wdata[8*b +: 8] : rd_val[8*b +: 8];
    end
  end

  assign wr_ctrl     = wr_en && (off == OFF_CTRL);
  assign wr_prescale = wr_en && (off == OFF_PRESCALE);
  assign wr_reload   = wr_en && (off == OFF_RELOAD);
  assign wr_count    = wr_en && (off == OFF_COUNT);
  assign wr_status   = wr_en && (off == OFF_STATUS);
  assign wr_cmp      = wr_en && (off == OFF_CMP) && HAS_CMP;

  assign tick   = ctrl_en && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      reload      <= 32'd0;
      count       <= 32'd0;
      expired     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= wr_word[0];
        ctrl_auto   <= wr_word[1];
        ctrl_irq_en <= wr_word[2];
      end else if (expire && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end

      if (wr_prescale) prescale <= wr_word[PRESCALE_W-1:0];
      if (wr_reload)   reload   <= wr_word;

      if ((wr_ctrl && !wr_word[0]) || wr_prescale) pcnt <= '0;
      else if (ctrl_en) pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);

      // A bus write to COUNT overrides both decrement and reload on the same edge.
      if (wr_count) count <= wr_word;
      else if (tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (ctrl_auto) count <= reload;
      end

      if (expire) expired <= 1'b1;
      else if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) expired <= 1'b0;

      irq <= expired && ctrl_irq_en;
    end
  end

`ifdef IOMEM_TIMER_PWM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp     <= 32'd0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_cmp) cmp <= wr_word;
      pwm_out <= ctrl_en && (count < cmp);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule
